// File: rtl/fetch_align_buffer_if.sv
// Fetch-side bundle: instruction memory request/response, redirect/stall
// controls from the pipeline, and the aligned instruction presented downstream.
interface fetch_align_buffer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_is_c;
    logic [31:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_is_c, instr_pc,
        input  imem_rvalid, imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_is_c, instr_pc,
        output imem_rvalid, imem_rdata, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/fetch_align_buffer.sv
// Word fetcher feeding a halfword queue; presents one 16- or 32-bit instruction
// per cycle, including 32-bit instructions that straddle a word boundary.
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH_HW = 4
) (
    input  logic                 clk,
    input  logic                 rst,   // asynchronous, active low
    fetch_align_buffer_if.master bus
);
    localparam int CW = $clog2(DEPTH_HW + 1);

    // IDLE: nothing in flight; WAIT: response expected; STALE: response in
    // flight belongs to a flushed path and must be dropped.
    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_STALE} fstate_t;

    fstate_t                    state, state_n;
    logic [DEPTH_HW-1:0][15:0]  q, q_n;
    logic [CW-1:0]              count, count_n;
    logic [31:0]                fetch_addr, fetch_addr_n;
    logic [31:0]                out_pc, out_pc_n;
    logic                       drop_low, drop_low_n;

    logic          is_c, valid, pop, issue, accept;
    logic [CW-1:0] pop_n, tail;
    logic [15:0]   hw0, hw1;

    assign hw0   = q[0];
    assign hw1   = q[1];
    assign is_c  = (hw0[1:0] != 2'b11);
    assign valid = is_c ? (count != '0) : (count >= CW'(2));

    assign bus.instr_valid = valid;
    assign bus.instr       = !valid ? 32'h0 : (is_c ? {16'h0, hw0} : {hw1, hw0});
    assign bus.instr_is_c  = valid & is_c;
    assign bus.instr_pc    = out_pc;

    assign pop    = valid & ~bus.stall & ~bus.redirect;
    assign pop_n  = !pop ? CW'(0) : (is_c ? CW'(1) : CW'(2));
    assign tail   = count - pop_n;
    // Gated by reset so no request escapes while reset is held.
    assign issue  = rst & (state == F_IDLE) & ~bus.redirect &
                    (count <= CW'(DEPTH_HW - 2));
    assign accept = bus.imem_rvalid & (state == F_WAIT) & ~bus.redirect;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_addr;

    always_comb begin
        state_n = state;
        case (state)
            F_IDLE:  if (issue) state_n = F_WAIT;
            F_WAIT: begin
                if (bus.redirect)
                    state_n = bus.imem_rvalid ? F_IDLE : F_STALE;
                else if (bus.imem_rvalid)
                    state_n = F_IDLE;
            end
            F_STALE: if (bus.imem_rvalid) state_n = F_IDLE;
            default: state_n = F_IDLE;
        endcase
    end

    always_comb begin
        q_n          = q;
        count_n      = count;
        fetch_addr_n = fetch_addr;
        out_pc_n     = out_pc;
        drop_low_n   = drop_low;
        if (bus.redirect) begin
            count_n      = '0;
            out_pc_n     = bus.redirect_pc & 32'hFFFF_FFFE;
            fetch_addr_n = bus.redirect_pc & 32'hFFFF_FFFC;
            drop_low_n   = bus.redirect_pc[1];
        end else begin
            if (issue)
                fetch_addr_n = fetch_addr + 32'd4;
            if (pop) begin
                if (is_c) begin
                    for (int i = 0; i < DEPTH_HW - 1; i++) q_n[i] = q[i+1];
                    q_n[DEPTH_HW-1] = '0;
                    out_pc_n = out_pc + 32'd2;
                end else begin
                    for (int i = 0; i < DEPTH_HW - 2; i++) q_n[i] = q[i+2];
                    q_n[DEPTH_HW-2] = '0;
                    q_n[DEPTH_HW-1] = '0;
                    out_pc_n = out_pc + 32'd4;
                end
            end
            count_n = tail;
            // Push lands after the pop has compacted the queue toward slot 0.
            if (accept) begin
                for (int i = 0; i < DEPTH_HW; i++) begin
                    if (i == int'(tail))
                        q_n[i] = drop_low ? bus.imem_rdata[31:16] : bus.imem_rdata[15:0];
                    else if (!drop_low && i == int'(tail) + 1)
                        q_n[i] = bus.imem_rdata[31:16];
                end
                count_n    = tail + (drop_low ? CW'(1) : CW'(2));
                drop_low_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= F_IDLE;
            q          <= '0;
            count      <= '0;
            fetch_addr <= RESET_PC & 32'hFFFF_FFFC;
            out_pc     <= RESET_PC;
            drop_low   <= RESET_PC[1];
        end else begin
            state      <= state_n;
            q          <= q_n;
            count      <= count_n;
            fetch_addr <= fetch_addr_n;
            out_pc     <= out_pc_n;
            drop_low   <= drop_low_n;
        end
    end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer: behavioural memory with adjustable
// latency, hand-computed instruction/PC sequences per scenario.
module tb_fetch_align_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_align_buffer_if bus();

    fetch_align_buffer #(.RESET_PC(32'h0), .DEPTH_HW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:255];
    logic [31:0] req_log [$];
    int          lat = 1;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: latches the request at mid-cycle, answers lat cycles later.
    initial begin
        int          pend;
        logic [31:0] paddr;
        pend = 0;
        paddr = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem[paddr[9:2]];
                end
            end
            if (bus.imem_req === 1'b1) begin
                paddr = bus.imem_addr;
                pend  = lat;
                req_log.push_back(bus.imem_addr);
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.stall = 1'b0;
        repeat (6) tick();
        req_log.delete();
        rst = 1'b1;
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] ei,
                                input logic [31:0] epc, input logic ec);
        int k;
        k = 0;
        while (bus.instr_valid !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        chk({tag, "_v"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_i"}, bus.instr, ei);
        chk({tag, "_pc"}, bus.instr_pc, epc);
        chk({tag, "_c"}, 32'(bus.instr_is_c), 32'(ec));
        tick();
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
        chk(tag, (req_log.size() > idx) ? req_log[idx] : 32'hFFFF_FFFF, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.stall = 1'b0;

        // Reset values while held, then two 32-bit instructions.
        fill_mem();
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h0010_0113;
        lat = 1;
        do_reset();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_isc", 32'(bus.instr_is_c), 32'd0);
        chk("rst_pc", bus.instr_pc, 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        tick();
        rst = 1'b1;
        expect_instr("t1a", 32'h00A0_0093, 32'h0, 1'b0);
        expect_instr("t1b", 32'h0010_0113, 32'h4, 1'b0);

        // Two compressed instructions from one word.
        fill_mem();
        mem[0] = 32'h0505_4501;
        do_reset();
        expect_instr("t2a", 32'h0000_4501, 32'h0, 1'b1);
        expect_instr("t2b", 32'h0000_0505, 32'h2, 1'b1);
        chk_log("t2_addr", 1, 32'h4);

        // 32-bit instruction straddling words 0 and 1.
        fill_mem();
        mem[0] = 32'h0093_4501;
        mem[1] = 32'h0000_00A0;
        lat = 3;
        do_reset();
        expect_instr("t3a", 32'h0000_4501, 32'h0, 1'b1);
        chk("t3_wait", 32'(bus.instr_valid), 32'd0);
        expect_instr("t3b", 32'h00A0_0093, 32'h2, 1'b0);

        // Redirect to 0x102 while the first fetch is outstanding.
        fill_mem();
        mem[64] = 32'h4505_FFFF;
        mem[65] = 32'h0000_4509;
        lat = 4;
        do_reset();
        tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        #1;
        chk("t4_noreq", 32'(bus.imem_req), 32'd0);
        tick();
        bus.redirect = 1'b0;
        expect_instr("t4a", 32'h0000_4505, 32'h102, 1'b1);
        expect_instr("t4b", 32'h0000_4509, 32'h104, 1'b1);
        chk_log("t4_addr", 1, 32'h100);

        // Full queue under stall holds outputs and stops fetching.
        fill_mem();
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'h0020_8193;
        lat = 1;
        do_reset();
        bus.stall = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_instr", bus.instr, 32'h00A0_0093);
            chk("t5_pc", bus.instr_pc, 32'h0);
            chk("t5_req", 32'(bus.imem_req), 32'd0);
            tick();
        end
        bus.stall = 1'b0;
        expect_instr("t5a", 32'h00A0_0093, 32'h0, 1'b0);
        expect_instr("t5b", 32'h0010_0113, 32'h4, 1'b0);
        expect_instr("t5c", 32'h0020_8193, 32'h8, 1'b0);

        // Reset mid-fetch: immediate reset values, late response ignored.
        fill_mem();
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h0010_0113;
        lat = 4;
        do_reset();
        expect_instr("t6a", 32'h00A0_0093, 32'h0, 1'b0);
        chk("t6_pc_pre", bus.instr_pc, 32'h4);
        rst = 1'b0;
        #1;
        chk("t6_pc", bus.instr_pc, 32'h0);
        chk("t6_valid", 32'(bus.instr_valid), 32'd0);
        chk("t6_instr", bus.instr, 32'd0);
        chk("t6_req", 32'(bus.imem_req), 32'd0);
        repeat (6) tick();
        req_log.delete();
        rst = 1'b1;
        expect_instr("t6b", 32'h00A0_0093, 32'h0, 1'b0);
        expect_instr("t6c", 32'h0010_0113, 32'h4, 1'b0);
        chk_log("t6_addr", 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
